// File: rtl/sonic_trig_ctrl.sv
// Ultrasonic ranging sequencer: drives TRIG, waits for echo result or timeout,
// publishes one measurement per trigger, then holds off before re-triggering.
//
// Ports:
//   clk, rst_n         clock, async active-low reset
//   en                 run periodic measurements while high
//   trig               registered sensor trigger pulse
//   idle_o             high while no measurement is in flight
//   e_done             echo timer done (level, edge-detected here)
//   echo_time_i        echo width, valid with e_done
//   re_idle            echo timer overlength timeout
//   meas_valid         1-cycle pulse when meas_time/timeout update
//   meas_time          last echo width, 0 on timeout
//   timeout            last measurement timed out
//   busy               high in any state other than IDLE
module sonic_trig_ctrl #(
  parameter int TRIG_CYC = 1000,
  parameter int WAIT_MAX = 4000000,
  parameter int HOLD_CYC = 6000000,
  parameter int TW       = 33
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          en,
  output logic          trig,
  output logic          idle_o,
  input  logic          e_done,
  input  logic [TW-1:0] echo_time_i,
  input  logic          re_idle,
  output logic          meas_valid,
  output logic [TW-1:0] meas_time,
  output logic          timeout,
  output logic          busy
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_TRIG = 2'd1,
    S_WAIT = 2'd2,
    S_HOLD = 2'd3
  } state_t;

  localparam logic [31:0] TRIG_LAST = 32'(TRIG_CYC - 1);
  localparam logic [31:0] WAIT_LAST = 32'(WAIT_MAX - 1);
  localparam logic [31:0] HOLD_LAST = 32'(HOLD_CYC - 1);

  state_t        state, state_d;
  logic   [31:0] cnt;
  logic          e_done_q;
  logic          done_ev, to_ev;

  logic          trig_d, idle_d, busy_d, mv_d, to_d;
  logic [TW-1:0] mt_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      cnt      <= '0;
      e_done_q <= 1'b0;
    end else begin
      state    <= state_d;
      e_done_q <= e_done;
      if (state_d != state || state == S_IDLE)
        cnt <= '0;
      else
        cnt <= cnt + 32'd1;
    end
  end

  always_comb begin
    state_d = state;
    done_ev = 1'b0;
    to_ev   = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (en)
          state_d = S_TRIG;
      end
      S_TRIG: begin
        if (cnt == TRIG_LAST)
          state_d = S_WAIT;
      end
      S_WAIT: begin
        // Only a fresh rising e_done counts, so a level left high
        // from the last measurement cannot produce a second result.
        if (e_done && !e_done_q) begin
          done_ev = 1'b1;
          state_d = S_HOLD;
        end else if (re_idle || cnt == WAIT_LAST) begin
          to_ev   = 1'b1;
          state_d = S_HOLD;
        end
      end
      S_HOLD: begin
        if (cnt == HOLD_LAST)
          state_d = en ? S_TRIG : S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs are decoded from the next state and registered,
  // so they line up with the state they describe.
  always_comb begin
    trig_d = (state_d == S_TRIG);
    idle_d = (state_d == S_IDLE) || (state_d == S_HOLD);
    busy_d = (state_d != S_IDLE);
    mv_d   = done_ev | to_ev;
    mt_d   = meas_time;
    to_d   = timeout;
    if (done_ev) begin
      mt_d = echo_time_i;
      to_d = 1'b0;
    end else if (to_ev) begin
      mt_d = '0;
      to_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      trig       <= 1'b0;
      idle_o     <= 1'b1;
      busy       <= 1'b0;
      meas_valid <= 1'b0;
      meas_time  <= '0;
      timeout    <= 1'b0;
    end else begin
      trig       <= trig_d;
      idle_o     <= idle_d;
      busy       <= busy_d;
      meas_valid <= mv_d;
      meas_time  <= mt_d;
      timeout    <= to_d;
    end
  end

endmodule

// File: tb/tb_sonic_trig_ctrl.sv
// Directed testbench for sonic_trig_ctrl with small timing parameters.
// Outputs are sampled on the falling clock edge.
module tb_sonic_trig_ctrl;

  localparam int TW = 33;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          en;
  logic          trig;
  logic          idle_o;
  logic          e_done;
  logic [TW-1:0] echo_time_i;
  logic          re_idle;
  logic          meas_valid;
  logic [TW-1:0] meas_time;
  logic          timeout;
  logic          busy;

  int checks = 0;
  int errors = 0;

  sonic_trig_ctrl #(
    .TRIG_CYC(4),
    .WAIT_MAX(50),
    .HOLD_CYC(10),
    .TW(TW)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .en(en),
    .trig(trig),
    .idle_o(idle_o),
    .e_done(e_done),
    .echo_time_i(echo_time_i),
    .re_idle(re_idle),
    .meas_valid(meas_valid),
    .meas_time(meas_time),
    .timeout(timeout),
    .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input longint got,
                     input longint exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  // From a sample with trig=1, count trig-high samples until it falls.
  task automatic count_trig(output int n);
    n = 0;
    while (trig && n < 100) begin
      n++;
      step();
    end
  endtask

  task automatic wait_trig(input string tag);
    int n;
    n = 0;
    while (!trig && n < 200) begin
      n++;
      step();
    end
    chk(tag, trig, 1);
  endtask

  initial begin
    int n, nv, ni;
    rst_n       = 1'b0;
    en          = 1'b0;
    e_done      = 1'b0;
    re_idle     = 1'b0;
    echo_time_i = '0;
    step();
    step();
    chk("rst_trig", trig, 0);
    chk("rst_idle", idle_o, 1);
    chk("rst_busy", busy, 0);
    chk("rst_mv", meas_valid, 0);
    chk("rst_mt", meas_time, 0);
    chk("rst_to", timeout, 0);

    // 1: trigger pulse length
    rst_n = 1'b1;
    en    = 1'b1;
    step();
    chk("t1_trig_rise", trig, 1);
    chk("t1_idle_low", idle_o, 0);
    chk("t1_busy", busy, 1);
    count_trig(n);
    chk("t1_trig_len", n, 4);

    // 2: echo result, e_done held 3 cycles
    e_done      = 1'b1;
    echo_time_i = TW'(1234);
    step();
    chk("t2_mv", meas_valid, 1);
    chk("t2_mt", meas_time, 1234);
    chk("t2_to", timeout, 0);
    nv = 0;
    ni = 0;
    for (int i = 0; i < 100 && idle_o; i++) begin
      if (i == 2)
        e_done = 1'b0;
      nv += int'(meas_valid);
      ni++;
      step();
    end
    chk("t2_one_mv", nv, 1);
    chk("t2_hold_len", ni, 10);
    chk("t2_next_trig", trig, 1);

    // 3: no response, local timeout after 50 WAIT cycles
    count_trig(n);
    chk("t3_trig_len", n, 4);
    n = 0;
    while (!meas_valid && n < 200) begin
      n++;
      step();
    end
    chk("t3_wait_len", n, 50);
    chk("t3_to", timeout, 1);
    chk("t3_mt", meas_time, 0);

    // 4: e_done and re_idle together, echo wins
    wait_trig("t4_trig");
    count_trig(n);
    e_done      = 1'b1;
    re_idle     = 1'b1;
    echo_time_i = TW'(77);
    step();
    e_done  = 1'b0;
    re_idle = 1'b0;
    chk("t4_mv", meas_valid, 1);
    chk("t4_mt", meas_time, 77);
    chk("t4_to", timeout, 0);
    step();
    chk("t4_mv_pulse", meas_valid, 0);
    chk("t4_mt_hold", meas_time, 77);

    // 5: en dropped during TRIG
    wait_trig("t5_trig");
    en = 1'b0;
    count_trig(n);
    chk("t5_trig_len", n, 4);
    e_done      = 1'b1;
    echo_time_i = TW'(55);
    step();
    e_done = 1'b0;
    chk("t5_mv", meas_valid, 1);
    chk("t5_mt", meas_time, 55);
    n = 0;
    while (busy && n < 100) begin
      n++;
      step();
    end
    chk("t5_hold_len", n, 10);
    chk("t5_idle", idle_o, 1);
    n = 0;
    for (int i = 0; i < 30; i++) begin
      n += int'(trig);
      step();
    end
    chk("t5_no_trig", n, 0);
    chk("t5_busy", busy, 0);

    // 6: async reset mid-TRIG
    en = 1'b1;
    step();
    chk("t6_trig", trig, 1);
    step();
    #2;
    rst_n = 1'b0;
    #1;
    chk("t6_rst_trig", trig, 0);
    chk("t6_rst_busy", busy, 0);
    chk("t6_rst_idle", idle_o, 1);
    step();
    rst_n = 1'b1;
    step();
    count_trig(n);
    chk("t6_trig_len", n, 4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
